// File: rtl/fetch_unit.sv
// fetch_unit: LC2K fetch stage holding the PC, fetching over imem req/valid and handing instructions to decode.
// Define FETCH_HALT_STOP_EN to stop fetching after a consumed halt (opcode 3'b110).
module fetch_unit #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_next,
    input  logic              pc_load,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] instr_pcplus1,
    output logic              halted
);
`ifdef FETCH_HALT_STOP_EN
    typedef enum logic [2:0] {IDLE, REQ, VALID, WAITPC, HALTED} state_t;
`else
    typedef enum logic [2:0] {IDLE, REQ, VALID, WAITPC} state_t;
`endif
    state_t state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pendPc;
    logic pendValid;
    assign imem_addr = pc;
    assign instr_pcplus1 = instr_pc + 1'b1;
`ifndef FETCH_HALT_STOP_EN
    assign halted = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc <= RESET_PC;
            pendPc <= '0;
            pendValid <= 1'b0;
            instr <= '0;
            instr_pc <= '0;
            imem_req <= 1'b0;
            instr_valid <= 1'b0;
`ifdef FETCH_HALT_STOP_EN
            halted <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (pc_load) begin
                        pendPc <= pc_next;
                        pendValid <= 1'b1;
                    end
                    if (imem_rvalid) begin
                        instr <= imem_rdata;
                        instr_pc <= pc;
                        imem_req <= 1'b0;
                        instr_valid <= 1'b1;
                        state <= VALID;
                    end
                end
                VALID: begin
                    if (!instr_ready) begin
                        if (pc_load) begin
                            pendPc <= pc_next;
                            pendValid <= 1'b1;
                        end
                    end else begin
                        instr_valid <= 1'b0;
                        pendValid <= 1'b0;
`ifdef FETCH_HALT_STOP_EN
                        if (instr[24:22] == 3'b110) begin
                            state <= HALTED;
                            halted <= 1'b1;
                        end else
`endif
                        if (pc_load || pendValid) begin
                            pc <= pc_load ? pc_next : pendPc;
                            imem_req <= 1'b1;
                            state <= REQ;
                        end else begin
                            state <= WAITPC;
                        end
                    end
                end
                WAITPC: begin
                    if (pc_load) begin
                        pc <= pc_next;
                        imem_req <= 1'b1;
                        state <= REQ;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit; memory responses push expectations, decode handshakes pop them.
module tb_fetch_unit;
    typedef struct {
        logic [31:0] data;
        logic [15:0] pc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] pc_next = '0;
    logic pc_load = 1'b0;
    logic imem_req;
    logic [15:0] imem_addr;
    logic imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic instr_valid;
    logic instr_ready = 1'b0;
    logic [31:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pcplus1;
    logic halted;
    exp_t sb[$];
    int nChecks = 0;
    int nFail = 0;

    fetch_unit dut (
        .clk(clk), .reset(reset), .pc_next(pc_next), .pc_load(pc_load),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
        .instr_pcplus1(instr_pcplus1), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called at a negedge; counts request cycles at the right address, answers after `waits` cycles.
    task automatic serve(input logic [15:0] pc, input logic [31:0] data, input int waits, output int seen);
        int t = 0;
        seen = 0;
        while (!imem_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (imem_req) begin
            for (int w = 0; w <= waits; w++) begin
                if (imem_req === 1'b1 && imem_addr === pc) seen++;
                if (w == waits) begin
                    imem_rvalid = 1'b1;
                    imem_rdata = data;
                    sb.push_back('{data, pc});
                end
                @(negedge clk);
            end
            imem_rvalid = 1'b0;
            imem_rdata = 32'hDEADBEEF;
        end
    endtask

    task automatic accept(input bit load, input logic [15:0] nxt);
        instr_ready = 1'b1;
        pc_load = load;
        pc_next = nxt;
        @(negedge clk);
        instr_ready = 1'b0;
        pc_load = 1'b0;
    endtask

    task automatic pulse(input logic [15:0] nxt);
        pc_load = 1'b1;
        pc_next = nxt;
        @(negedge clk);
        pc_load = 1'b0;
    endtask

    task automatic test_reset();
        int seen;
        exp_t e;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        nChecks++;
        if (imem_req !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin
            nFail++;
            $display("FAIL reset_ctrl: req=%b valid=%b halted=%b, required 0 0 0", imem_req, instr_valid, halted);
        end
        nChecks++;
        if (imem_addr !== 16'h0 || instr !== 32'h0 || instr_pc !== 16'h0) begin
            nFail++;
            $display("FAIL reset_data: addr=%h instr=%h pc=%h, required 0 0 0", imem_addr, instr, instr_pc);
        end
        reset = 1'b0;
        #1;
        nChecks++;
        if (imem_req !== 1'b0) begin
            nFail++;
            $display("FAIL idle_cycle: req=%b, required 0", imem_req);
        end
        @(negedge clk);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin
            nFail++;
            $display("FAIL first_req: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
        serve(16'h0, 32'h00810003, 0, seen);
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL first_fetch: no expected entry");
        end else begin
            e = sb.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc || instr_pcplus1 !== 16'h1) begin
                nFail++;
                $display("FAIL first_fetch: valid=%b instr=%h pc=%h pc1=%h, required 1 %h %h 0001",
                         instr_valid, instr, instr_pc, instr_pcplus1, e.data, e.pc);
            end
        end
        accept(1'b0, 16'h0);
        nChecks++;
        if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
            nFail++;
            $display("FAIL waitpc: valid=%b req=%b, required 0 0", instr_valid, imem_req);
        end
    endtask

    task automatic test_wait_stall();
        int seen;
        exp_t e;
        imem_rvalid = 1'b1;
        imem_rdata = 32'h0BAD0BAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        nChecks++;
        if (instr_valid !== 1'b0 || instr !== 32'h00810003) begin
            nFail++;
            $display("FAIL stray_rvalid: valid=%b instr=%h, required 0 00810003", instr_valid, instr);
        end
        pulse(16'h0005);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0005) begin
            nFail++;
            $display("FAIL load_to_addr: req=%b addr=%h, required 1 0005", imem_req, imem_addr);
        end
        serve(16'h0005, 32'h12345678, 3, seen);
        nChecks++;
        if (seen !== 4) begin
            nFail++;
            $display("FAIL wait_req_stable: stable req cycles=%0d, required 4", seen);
        end
        for (int i = 0; i < 2; i++) begin
            nChecks++;
            if (sb.size() == 0 || instr_valid !== 1'b1 || instr !== sb[0].data || instr_pc !== sb[0].pc) begin
                nFail++;
                $display("FAIL stall_hold: valid=%b instr=%h pc=%h, required 1 12345678 0005", instr_valid, instr, instr_pc);
            end
            @(negedge clk);
        end
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL stall_fetch: no expected entry");
        end else begin
            e = sb.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                nFail++;
                $display("FAIL stall_fetch: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        accept(1'b1, 16'h0010);
    endtask

    task automatic test_back_to_back();
        int seen;
        exp_t e;
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || instr_valid !== 1'b0) begin
            nFail++;
            $display("FAIL b2b_req: req=%b addr=%h valid=%b, required 1 0010 0", imem_req, imem_addr, instr_valid);
        end
        serve(16'h0010, 32'hA5A50010, 0, seen);
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL b2b_fetch: no expected entry");
        end else begin
            e = sb.pop_front();
            if (seen !== 1 || instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                nFail++;
                $display("FAIL b2b_fetch: seen=%0d valid=%b instr=%h pc=%h, required 1 1 %h %h", seen, instr_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        accept(1'b0, 16'h0);
    endtask

    task automatic test_pending();
        int seen;
        exp_t e;
        pulse(16'h0040);
        fork
            serve(16'h0040, 32'h00400040, 3, seen);
            begin
                pc_load = 1'b1;
                pc_next = 16'h0020;
                @(negedge clk);
                pc_next = 16'h0030;
                @(negedge clk);
                pc_load = 1'b0;
            end
        join
        nChecks++;
        if (seen !== 4) begin
            nFail++;
            $display("FAIL pend_inflight: stable req cycles at 0040=%0d, required 4", seen);
        end
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL pend_fetch: no expected entry");
        end else begin
            e = sb.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                nFail++;
                $display("FAIL pend_fetch: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        accept(1'b0, 16'h0);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0030) begin
            nFail++;
            $display("FAIL pend_apply: req=%b addr=%h, required 1 0030", imem_req, imem_addr);
        end
        serve(16'h0030, 32'h00300030, 1, seen);
        pulse(16'h0060);
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL pend_valid_fetch: no expected entry");
        end else begin
            e = sb.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                nFail++;
                $display("FAIL pend_valid_fetch: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        accept(1'b0, 16'h0);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0060) begin
            nFail++;
            $display("FAIL pend_valid_apply: req=%b addr=%h, required 1 0060", imem_req, imem_addr);
        end
        serve(16'h0060, 32'h00600060, 0, seen);
        if (sb.size() != 0) e = sb.pop_front();
        accept(1'b0, 16'h0);
    endtask

    task automatic test_wrap();
        int seen;
        exp_t e;
        pulse(16'hFFFF);
        serve(16'hFFFF, 32'h0000FFFF, 0, seen);
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL wrap: no expected entry");
        end else begin
            e = sb.pop_front();
            if (instr_valid !== 1'b1 || instr_pc !== e.pc || instr_pcplus1 !== 16'h0000) begin
                nFail++;
                $display("FAIL wrap: valid=%b pc=%h pc1=%h, required 1 %h 0000", instr_valid, instr_pc, instr_pcplus1, e.pc);
            end
        end
        accept(1'b0, 16'h0);
    endtask

    task automatic test_reset_midreq();
        int seen;
        exp_t e;
        pulse(16'h0077);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0077) begin
            nFail++;
            $display("FAIL midreq_req: req=%b addr=%h, required 1 0077", imem_req, imem_addr);
        end
        #2;
        reset = 1'b1;
        #1;
        nChecks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0 || instr_valid !== 1'b0) begin
            nFail++;
            $display("FAIL async_reset: req=%b addr=%h valid=%b, required 0 0000 0", imem_req, imem_addr, instr_valid);
        end
        imem_rvalid = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        @(negedge clk);
        nChecks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0 || instr_valid !== 1'b0) begin
            nFail++;
            $display("FAIL dropped_resp: req=%b addr=%h valid=%b, required 1 0000 0", imem_req, imem_addr, instr_valid);
        end
        serve(16'h0, 32'h00000ACE, 0, seen);
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL post_reset_fetch: no expected entry");
        end else begin
            e = sb.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                nFail++;
                $display("FAIL post_reset_fetch: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        accept(1'b0, 16'h0);
    endtask

    task automatic test_halt();
        int seen;
        exp_t e;
        pulse(16'h0100);
        serve(16'h0100, 32'h01800000, 0, seen);
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL halt_fetch: no expected entry");
        end else begin
            e = sb.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                nFail++;
                $display("FAIL halt_fetch: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        accept(1'b0, 16'h0);
`ifdef FETCH_HALT_STOP_EN
        nChecks++;
        if (halted !== 1'b1 || imem_req !== 1'b0) begin
            nFail++;
            $display("FAIL halt_enter: halted=%b req=%b, required 1 0", halted, imem_req);
        end
        pulse(16'h0200);
        @(negedge clk);
        nChecks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            nFail++;
            $display("FAIL halt_hold: halted=%b req=%b valid=%b, required 1 0 0", halted, imem_req, instr_valid);
        end
        reset = 1'b1;
        #1;
        nChecks++;
        if (halted !== 1'b0) begin
            nFail++;
            $display("FAIL halt_reset: halted=%b, required 0", halted);
        end
        @(negedge clk);
        reset = 1'b0;
`else
        nChecks++;
        if (halted !== 1'b0 || imem_req !== 1'b0) begin
            nFail++;
            $display("FAIL halt_ignored: halted=%b req=%b, required 0 0", halted, imem_req);
        end
        pulse(16'h0200);
        nChecks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0200) begin
            nFail++;
            $display("FAIL halt_restart: halted=%b req=%b addr=%h, required 0 1 0200", halted, imem_req, imem_addr);
        end
        serve(16'h0200, 32'h00000200, 0, seen);
        nChecks++;
        if (sb.size() == 0) begin
            nFail++;
            $display("FAIL restart_fetch: no expected entry");
        end else begin
            e = sb.pop_front();
            if (instr_valid !== 1'b1 || instr !== e.data || instr_pc !== e.pc) begin
                nFail++;
                $display("FAIL restart_fetch: valid=%b instr=%h pc=%h, required 1 %h %h", instr_valid, instr, instr_pc, e.data, e.pc);
            end
        end
        accept(1'b0, 16'h0);
`endif
    endtask

    initial begin
        test_reset();
        test_wait_stall();
        test_back_to_back();
        test_pending();
        test_wrap();
        test_reset_midreq();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
